// File: rtl/sram_sched_pkg.sv
// Shared constants and helpers for the SRAM port scheduler.
// Grant statistics are built only when SRAM_SCHED_STATS_EN is defined.
package sram_sched_pkg;

    localparam int STAT_W     = 16;
    localparam int MASK_W     = 4;
    localparam int ERR_ORPHAN = 0;
    localparam int ERR_CREDIT = 1;

    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A zero byte mask marks a read command.
    function automatic logic mask_is_read(input logic [MASK_W-1:0] mask);
        return (mask == '0);
    endfunction

endpackage

// File: rtl/sram_port_scheduler_if.sv
// Requester and SRAM command/return signals of the port scheduler.
// master = environment (requesters + SRAM controller), slave = scheduler.
interface sram_port_scheduler_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 32
) ();
    import sram_sched_pkg::*;

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_data;
    logic [NUM_PORTS*MASK_W-1:0] req_mask;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic [NUM_PORTS-1:0]        rsp_pop;
    logic                        sram_addr_valid;
    logic                        sram_ready;
    logic [ADDR_W-1:0]           sram_addr;
    logic [DATA_W-1:0]           sram_data_in;
    logic [MASK_W-1:0]           sram_write_mask;
    logic [DATA_W-1:0]           sram_data_out;
    logic                        sram_data_out_valid;

    modport master (
        output req_valid, req_addr, req_data, req_mask, rsp_pop,
               sram_ready, sram_data_out, sram_data_out_valid,
        input  req_ready, rsp_valid, rsp_data,
               sram_addr_valid, sram_addr, sram_data_in, sram_write_mask
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_mask, rsp_pop,
               sram_ready, sram_data_out, sram_data_out_valid,
        output req_ready, rsp_valid, rsp_data,
               sram_addr_valid, sram_addr, sram_data_in, sram_write_mask
    );

endinterface

// File: rtl/sram_tag_fifo.sv
// In-flight read tag FIFO holding the issuing port id of each outstanding read.
// Pop on empty with a simultaneous push bypasses the pushed id straight to pop_data_o.
module sram_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_data_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 pop_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          push_en;
    logic          pop_en;

    assign full       = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign push_en    = push_i && (!full || pop_i);
    assign pop_en     = pop_i && (!empty_o || push_i);
    assign pop_data_o = empty_o ? push_data_i : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sram_port_scheduler.sv
// Round-robin scheduler sharing one SRAM command port, with per-port read credits and read-data steering.
// Optional per-port grant counters are enabled with SRAM_SCHED_STATS_EN.
module sram_port_scheduler
    import sram_sched_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_W          = 18,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TAG_DEPTH       = 8
) (
    input  logic                    sram_clock,
    input  logic                    reset,
    sram_port_scheduler_if.slave    bus,
    output logic [1:0]              err_sticky
`ifdef SRAM_SCHED_STATS_EN
    ,
    input  logic [port_idx_w(NUM_PORTS)-1:0] stat_sel,
    output logic [STAT_W-1:0]                stat_grants
`endif
);

    localparam int PW  = port_idx_w(NUM_PORTS);
    localparam int CRW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TCW = $clog2(TAG_DEPTH + 1);
    localparam logic [CRW-1:0]       CREDIT_MAX = CRW'(MAX_OUTSTANDING);
    localparam logic [NUM_PORTS-1:0] ONE        = NUM_PORTS'(1);

    logic [ADDR_W-1:0] addr_a [NUM_PORTS];
    logic [DATA_W-1:0] data_a [NUM_PORTS];
    logic [MASK_W-1:0] mask_a [NUM_PORTS];
    logic [NUM_PORTS-1:0] eligible;

    logic              cmd_valid_q, cmd_valid_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic [MASK_W-1:0] cmd_mask_q, cmd_mask_d;
    logic [PW-1:0]     cmd_port_q, cmd_port_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CRW-1:0]    credit_q [NUM_PORTS];
    logic [CRW-1:0]    credit_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        err_q, err_d;

    logic           slot_free;
    logic           cmd_is_read;
    logic           tag_push;
    logic           tag_pop;
    logic           tag_empty;
    logic           tag_room;
    logic [PW-1:0]  tag_pop_data;
    logic [TCW-1:0] tag_count;
    logic           orphan;
    logic           credit_ovf;
    logic           grant_any;
    logic           grant_is_read;
    logic [PW-1:0]  grant_idx;
    logic [PW-1:0]  scan_idx;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
            data_a[i] = bus.req_data[i*DATA_W +: DATA_W];
            mask_a[i] = bus.req_mask[i*MASK_W +: MASK_W];
        end
    end

    assign slot_free   = !cmd_valid_q || bus.sram_ready;
    assign cmd_is_read = mask_is_read(cmd_mask_q);
    assign tag_push    = cmd_valid_q && bus.sram_ready && cmd_is_read;
    // A read still sitting in the command register already owns a tag slot.
    assign tag_room    = ({1'b0, tag_count} + {{TCW{1'b0}}, cmd_valid_q && cmd_is_read})
                         < (TCW+1)'(TAG_DEPTH);

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = bus.req_valid[i] &&
                          (!mask_is_read(mask_a[i]) || (credit_q[i] != '0 && tag_room));
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan_idx = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!grant_any && slot_free && !reset && eligible[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant_is_read = mask_is_read(mask_a[grant_idx]);
    assign bus.req_ready = grant_any ? (ONE << grant_idx) : '0;

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_mask_d  = cmd_mask_q;
        cmd_port_d  = cmd_port_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_any) begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = addr_a[grant_idx];
            cmd_data_d  = data_a[grant_idx];
            cmd_mask_d  = mask_a[grant_idx];
            cmd_port_d  = grant_idx;
            rr_ptr_d    = grant_idx;
        end else if (bus.sram_ready) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_comb begin
        credit_ovf = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            credit_d[i] = credit_q[i];
            if (grant_any && grant_idx == PW'(i) && grant_is_read && !bus.rsp_pop[i]) begin
                credit_d[i] = credit_q[i] - CRW'(1);
            end else if (bus.rsp_pop[i] && !(grant_any && grant_idx == PW'(i) && grant_is_read)) begin
                if (credit_q[i] == CREDIT_MAX) credit_ovf = 1'b1;
                else                           credit_d[i] = credit_q[i] + CRW'(1);
            end
        end
    end

    sram_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (PW)
    ) u_tag_fifo (
        .clk         (sram_clock),
        .rst         (reset),
        .push_i      (tag_push),
        .push_data_i (cmd_port_q),
        .pop_i       (tag_pop),
        .pop_data_o  (tag_pop_data),
        .empty_o     (tag_empty),
        .count_o     (tag_count)
    );

    assign orphan  = bus.sram_data_out_valid && tag_empty && !tag_push;
    assign tag_pop = bus.sram_data_out_valid && !orphan;

    always_comb begin
        rsp_valid_d = tag_pop ? (ONE << tag_pop_data) : '0;
        rsp_data_d  = tag_pop ? bus.sram_data_out : rsp_data_q;
        err_d       = err_q;
        if (orphan)     err_d[ERR_ORPHAN] = 1'b1;
        if (credit_ovf) err_d[ERR_CREDIT] = 1'b1;
    end

    always_ff @(posedge sram_clock or posedge reset) begin
        if (reset) begin
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_mask_q  <= '0;
            cmd_port_q  <= '0;
            rr_ptr_q    <= PW'(NUM_PORTS - 1);
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= '0;
            for (int i = 0; i < NUM_PORTS; i++) credit_q[i] <= CREDIT_MAX;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_mask_q  <= cmd_mask_d;
            cmd_port_q  <= cmd_port_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_PORTS; i++) credit_q[i] <= credit_d[i];
        end
    end

    assign bus.sram_addr_valid = cmd_valid_q;
    assign bus.sram_addr       = cmd_addr_q;
    assign bus.sram_data_in    = cmd_data_q;
    assign bus.sram_write_mask = cmd_mask_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_data        = rsp_data_q;
    assign err_sticky          = err_q;

`ifdef SRAM_SCHED_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q [NUM_PORTS];

    always_ff @(posedge sram_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) grant_cnt_q[i] <= '0;
        end else if (grant_any && grant_cnt_q[grant_idx] != '1) begin
            grant_cnt_q[grant_idx] <= grant_cnt_q[grant_idx] + STAT_W'(1);
        end
    end

    assign stat_grants = grant_cnt_q[stat_sel];
`endif

endmodule
